parking_gate_controller: RTL and testbench
==========================================

// Module: parking_gate_controller
// PURPOSE
//  Access controller for the parking gate: detects an arriving vehicle, validates a 16-bit PIN,
//  opens the gate, and raises alarms on repeated wrong PINs or tailgating. Behavioural FSM
//  upstream of synthesis; the netlist is mapped onto the team's NOT/NAND/NOR/BUF/DFF cell library
//  and simulated at gate level alongside the RTL.
// PARAMETERS
//  PASSWORD        16'h2B7A  correct PIN value
//  MAX_ATTEMPTS    3         wrong PINs (1..3) before PIN alarm
//  TIMEOUT_CYCLES  16        idle cycles in WAIT_PIN before abort (TIMEOUT_EN only)
// PORTS
//  clk             in   1   single clock; all state changes on rising edge
//  reset           in   1   asynchronous, active-high; clears everything immediately
//  arrival_sensor  in   1   vehicle present at entry
//  pass_sensor     in   1   vehicle has crossed the gate line
//  pin_valid       in   1   one-cycle strobe: pin_in holds an attempt
//  pin_in          in   16  PIN attempt, sampled only when pin_valid=1
//  gate_open       out  1   1 = command gate open
//  gate_close      out  1   1 = command gate closed (always ~gate_open)
//  pin_alarm       out  1   wrong-PIN limit reached
//  block_alarm     out  1   tailgating detected, gate locked
//  attempts        out  2   wrong attempts since last correct PIN (saturates at MAX_ATTEMPTS)
// BEHAVIOUR
//  - Moore FSM; state and all outputs registered; inputs sampled at rising edge N -> outputs
//    change at edge N (visible one cycle after stimulus is applied). No combinational in->out path.
//  - Reset (async): state=IDLE, gate_open=0, gate_close=1, pin_alarm=0, block_alarm=0, attempts=0;
//    reset mid-operation aborts any state, including BLOCKED and PIN_ALARM.
//  - States / transitions (priority top-down within a state):
//    IDLE:      arrival_sensor=1 -> WAIT_PIN. pin_valid ignored.
//    WAIT_PIN:  pin_valid & pin_in==PASSWORD -> OPEN, attempts=0.
//               pin_valid & wrong -> attempts+1; if new count==MAX_ATTEMPTS -> PIN_ALARM, else stay.
//    OPEN:      gate_open=1. pass_sensor & arrival_sensor same cycle -> BLOCKED (tailgate wins).
//               pass_sensor alone -> IDLE. pin_valid ignored.
//    PIN_ALARM: pin_alarm=1, gate closed. correct PIN -> OPEN, attempts=0, pin_alarm cleared.
//               wrong PINs ignored, attempts held at MAX_ATTEMPTS.
//    BLOCKED:   block_alarm=1, gate closed. correct PIN -> IDLE, block_alarm cleared; wrong ignored.
//  - Each cycle with pin_valid=1 is a distinct attempt; holding it high 2 cycles = 2 attempts.
//  - attempts never wraps; cleared only by correct PIN or reset. Persists through IDLE.
//  - arrival_sensor high while already in WAIT_PIN/OPEN (without pass_sensor) has no effect.
//  - Unused state encodings recover to IDLE on next edge with outputs in reset values.
// CONFIGURATION
//  PIN_TIMEOUT_EN defined: WAIT_PIN counter increments each cycle without pin_valid, cleared on
//   entry and on any pin_valid; reaching TIMEOUT_CYCLES -> IDLE (attempts kept, no alarm).
//   pin_valid on the expiry cycle takes priority over timeout.
//  PIN_TIMEOUT_EN undefined: no counter; WAIT_PIN held indefinitely.
// TESTING
//  - reset high mid-OPEN -> same cycle gate_open=0, gate_close=1, alarms 0, attempts=0.
//  - arrival=1, then pin_in=16'h2B7A strobe -> gate_open=1 next edge; pass_sensor=1 -> IDLE, gate closed.
//  - arrival, 3 wrong PINs (16'h0000) -> attempts 1,2,3; pin_alarm=1 after 3rd; then 16'h2B7A
//    -> pin_alarm=0, attempts=0, gate_open=1.
//  - in OPEN, pass_sensor=1 & arrival_sensor=1 same cycle -> block_alarm=1, gate_open=0; wrong PIN
//    no change; 16'h2B7A -> IDLE, block_alarm=0.
//  - PIN_TIMEOUT_EN: arrival, no strobe for 16 cycles -> IDLE on 16th edge; strobe on 16th -> evaluated.
//  - Run same vectors on RTL and cell-mapped netlist; outputs compared on falling edge must match.

Source files
------------

// File: rtl/parking_gate_controller_if.sv
// Sensor, PIN and gate/alarm signals of the parking gate controller.
// The controller connects through the slave modport; the environment driving it uses master.
interface parking_gate_controller_if;
    logic        arrival_sensor;
    logic        pass_sensor;
    logic        pin_valid;
    logic [15:0] pin_in;
    logic        gate_open;
    logic        gate_close;
    logic        pin_alarm;
    logic        block_alarm;
    logic [1:0]  attempts;

    modport master (
        output arrival_sensor, pass_sensor, pin_valid, pin_in,
        input  gate_open, gate_close, pin_alarm, block_alarm, attempts
    );

    modport slave (
        input  arrival_sensor, pass_sensor, pin_valid, pin_in,
        output gate_open, gate_close, pin_alarm, block_alarm, attempts
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Parking gate access FSM: vehicle arrival, PIN check, gate open, PIN/tailgate alarms.
// Optional WAIT_PIN inactivity timeout is enabled by defining PIN_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | gate closed, waiting for a vehicle
// WAIT_PIN  | vehicle present, waiting for a PIN attempt
// OPEN      | gate open until the vehicle passes
// PIN_ALARM | wrong-PIN limit reached, only the correct PIN releases
// BLOCKED   | tailgating detected, only the correct PIN releases
module parking_gate_controller #(
    parameter logic [15:0] PASSWORD     = 16'h2B7A,
    parameter int          MAX_ATTEMPTS = 3
`ifdef PIN_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 16
`endif
) (
    input logic                     clk,
    input logic                     reset,
    parking_gate_controller_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_PIN  = 3'd1;
    localparam logic [2:0] OPEN      = 3'd2;
    localparam logic [2:0] PIN_ALARM = 3'd3;
    localparam logic [2:0] BLOCKED   = 3'd4;

    localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

    logic [2:0] state, state_nxt;
    logic [1:0] attempts, attempts_nxt, attempts_inc;
    logic       gate_open, gate_close, pin_alarm, block_alarm;
    logic       pin_ok, pin_bad;

`ifdef PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr, tmr_nxt;
    logic          tmr_tc;

    assign tmr_tc = (tmr == TW'(1));
`endif

    assign pin_ok       = bus.pin_valid && (bus.pin_in == PASSWORD);
    assign pin_bad      = bus.pin_valid && (bus.pin_in != PASSWORD);
    assign attempts_inc = attempts + 2'd1;

    always_comb begin
        state_nxt    = state;
        attempts_nxt = attempts;
`ifdef PIN_TIMEOUT_EN
        tmr_nxt      = TW'(TIMEOUT_CYCLES);
`endif
        case (state)
            IDLE: begin
                if (bus.arrival_sensor)
                    state_nxt = WAIT_PIN;
            end
            WAIT_PIN: begin
                if (pin_ok) begin
                    state_nxt    = OPEN;
                    attempts_nxt = 2'd0;
                end else if (pin_bad) begin
                    // Saturating: the limit is reached exactly once before PIN_ALARM takes over.
                    if (attempts == MAX_ATT || attempts_inc == MAX_ATT) begin
                        attempts_nxt = MAX_ATT;
                        state_nxt    = PIN_ALARM;
                    end else begin
                        attempts_nxt = attempts_inc;
                    end
                end
`ifdef PIN_TIMEOUT_EN
                else if (tmr_tc) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
`endif
            end
            OPEN: begin
                if (bus.pass_sensor && bus.arrival_sensor)
                    state_nxt = BLOCKED;
                else if (bus.pass_sensor)
                    state_nxt = IDLE;
            end
            PIN_ALARM: begin
                if (pin_ok) begin
                    state_nxt    = OPEN;
                    attempts_nxt = 2'd0;
                end
            end
            BLOCKED: begin
                if (pin_ok)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                attempts_nxt = 2'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            attempts    <= 2'd0;
            gate_open   <= 1'b0;
            gate_close  <= 1'b1;
            pin_alarm   <= 1'b0;
            block_alarm <= 1'b0;
        end else begin
            state       <= state_nxt;
            attempts    <= attempts_nxt;
            gate_open   <= (state_nxt == OPEN);
            gate_close  <= (state_nxt != OPEN);
            pin_alarm   <= (state_nxt == PIN_ALARM);
            block_alarm <= (state_nxt == BLOCKED);
        end
    end

`ifdef PIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmr <= TW'(TIMEOUT_CYCLES);
        else
            tmr <= tmr_nxt;
    end
`endif

    assign bus.gate_open   = gate_open;
    assign bus.gate_close  = gate_close;
    assign bus.pin_alarm   = pin_alarm;
    assign bus.block_alarm = block_alarm;
    assign bus.attempts    = attempts;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller; covers the PIN_TIMEOUT_EN build when that macro is defined.
module tb_parking_gate_controller;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    parking_gate_controller_if bus ();

    parking_gate_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // {gate_open, gate_close, pin_alarm, block_alarm, attempts[1:0]}
    logic [5:0] obs;
    assign obs = {bus.gate_open, bus.gate_close, bus.pin_alarm, bus.block_alarm, bus.attempts};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arrival_sensor = 1'b0;
        bus.pass_sensor    = 1'b0;
        bus.pin_valid      = 1'b0;
        bus.pin_in         = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 6'b010000) $display("FAIL reset_state actual=%b required=%b", obs, 6'b010000);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        tick();
        total++;
        if (obs !== 6'b010000) $display("FAIL idle_after_reset actual=%b required=%b", obs, 6'b010000);
        else passed++;
    endtask

    task automatic test_open_pass();
        do_reset();
        tick();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        total++;
        if (obs !== 6'b010000) $display("FAIL wait_pin_closed actual=%b required=%b", obs, 6'b010000);
        else passed++;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b100000) $display("FAIL correct_pin_open actual=%b required=%b", obs, 6'b100000);
        else passed++;
        bus.pass_sensor = 1'b1;
        tick();
        bus.pass_sensor = 1'b0;
        total++;
        if (obs !== 6'b010000) $display("FAIL pass_to_idle actual=%b required=%b", obs, 6'b010000);
        else passed++;
        // IDLE ignores a correct PIN: a later bare arrival must not open the gate.
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b010000) $display("FAIL idle_ignores_pin actual=%b required=%b", obs, 6'b010000);
        else passed++;
    endtask

    task automatic test_pin_alarm();
        logic [5:0] exp_seq [4];
        exp_seq[0] = 6'b010001;
        exp_seq[1] = 6'b010010;
        exp_seq[2] = 6'b011011;
        exp_seq[3] = 6'b011011;
        do_reset();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        // pin_valid held high for four cycles: four distinct wrong attempts, the fourth ignored.
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== exp_seq[i]) $display("FAIL wrong_pin_%0d actual=%b required=%b", i + 1, obs, exp_seq[i]);
            else passed++;
        end
        bus.pin_in = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b100000) $display("FAIL alarm_release actual=%b required=%b", obs, 6'b100000);
        else passed++;
    endtask

    task automatic test_block();
        do_reset();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        bus.arrival_sensor = 1'b1;
        tick();
        total++;
        if (obs !== 6'b100000) $display("FAIL open_ignores_arrival actual=%b required=%b", obs, 6'b100000);
        else passed++;
        bus.pass_sensor = 1'b1;
        tick();
        bus.pass_sensor    = 1'b0;
        bus.arrival_sensor = 1'b0;
        total++;
        if (obs !== 6'b010100) $display("FAIL tailgate_block actual=%b required=%b", obs, 6'b010100);
        else passed++;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h1234;
        tick();
        total++;
        if (obs !== 6'b010100) $display("FAIL blocked_wrong_pin actual=%b required=%b", obs, 6'b010100);
        else passed++;
        bus.pin_in = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b010000) $display("FAIL blocked_release actual=%b required=%b", obs, 6'b010000);
        else passed++;
        // Released to IDLE, not WAIT_PIN: a correct PIN now must be ignored.
        bus.pin_valid = 1'b1;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b010000) $display("FAIL blocked_to_idle actual=%b required=%b", obs, 6'b010000);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 6'b010000) $display("FAIL reset_mid_open actual=%b required=%b", obs, 6'b010000);
        else passed++;
        reset = 1'b0;
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'hFFFF;
        tick();
        tick();
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b011011) $display("FAIL alarm_before_reset actual=%b required=%b", obs, 6'b011011);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 6'b010000) $display("FAIL reset_mid_alarm actual=%b required=%b", obs, 6'b010000);
        else passed++;
        reset = 1'b0;
    endtask

`ifdef PIN_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h0001;
        tick();
        bus.pin_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (obs !== 6'b010001) $display("FAIL timeout_pre_expiry actual=%b required=%b", obs, 6'b010001);
        else passed++;
        tick();
        // Now in IDLE with attempts kept; a correct PIN is ignored.
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b010001) $display("FAIL timeout_to_idle actual=%b required=%b", obs, 6'b010001);
        else passed++;
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.pin_valid = 1'b1;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b100000) $display("FAIL pin_on_expiry actual=%b required=%b", obs, 6'b100000);
        else passed++;
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        bus.arrival_sensor = 1'b1;
        tick();
        bus.arrival_sensor = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        bus.pin_valid = 1'b1;
        bus.pin_in    = 16'h2B7A;
        tick();
        bus.pin_valid = 1'b0;
        total++;
        if (obs !== 6'b100000) $display("FAIL wait_pin_held actual=%b required=%b", obs, 6'b100000);
        else passed++;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_open_pass();
        test_pin_alarm();
        test_block();
        test_async_reset();
`ifdef PIN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
